// File: rtl/issue_queue_pkg.sv
// Shared types for the issue queue slice.
//   R_UOp    : renamed uop as held in the queue and handed to operand load.
//   RES_UOp  : writeback result as seen on a snoop port (only tagDst is used here).
//   FuncUnit : target functional unit of a uop.
//   is_younger(a, b) : age compare on wrapping sequence numbers.
package issue_queue_pkg;

    localparam int SQN_WIDTH = 6;
    localparam int TAG_WIDTH = 7;

    typedef enum logic [1:0] {
        FU_INT,
        FU_LSU,
        FU_MUL,
        FU_BRANCH
    } FuncUnit;

    typedef struct packed {
        logic [31:0]          imm;
        logic [TAG_WIDTH-1:0] tagA;
        logic [TAG_WIDTH-1:0] tagB;
        logic                 immB;
        logic [TAG_WIDTH-1:0] tagDst;
        logic [SQN_WIDTH-1:0] sqN;
        FuncUnit              fu;
    } R_UOp;

    typedef struct packed {
        logic [31:0]          result;
        logic [TAG_WIDTH-1:0] tagDst;
        logic [SQN_WIDTH-1:0] sqN;
    } RES_UOp;

    // a is younger than b when (a - b) is strictly positive as a signed
    // SQN_WIDTH-bit number, so the compare survives sequence-number wrap.
    function automatic logic is_younger(input logic [SQN_WIDTH-1:0] a,
                                        input logic [SQN_WIDTH-1:0] b);
        logic [SQN_WIDTH-1:0] diff;
        diff = a - b;
        return !diff[SQN_WIDTH-1] && (diff != '0);
    endfunction

endpackage

// File: rtl/issue_queue_if.sv
// Bundle of all non-clock/reset signals of the issue queue.
//   enqueue side   : IN_enqValid, IN_enqUOp, IN_enqReadyA/B, OUT_full, OUT_freeCount
//   snoop side     : IN_wbHasResult, IN_wbUOp (one per writeback port)
//   flush side     : IN_invalidate, IN_invalidateSqN
//   issue side     : IN_stall, OUT_uopValid, OUT_uop
// master = the surrounding pipeline, slave = the queue itself.
interface issue_queue_if #(
    parameter int SIZE    = 8,
    parameter int NUM_WBS = 3
);
    import issue_queue_pkg::*;

    localparam int CNT_WIDTH = $clog2(SIZE + 1);

    logic                 IN_enqValid;
    R_UOp                 IN_enqUOp;
    logic                 IN_enqReadyA;
    logic                 IN_enqReadyB;
    logic                 OUT_full;
    logic [CNT_WIDTH-1:0] OUT_freeCount;
    logic [NUM_WBS-1:0]   IN_wbHasResult;
    RES_UOp [NUM_WBS-1:0] IN_wbUOp;
    logic                 IN_invalidate;
    logic [SQN_WIDTH-1:0] IN_invalidateSqN;
    logic                 IN_stall;
    logic                 OUT_uopValid;
    R_UOp                 OUT_uop;

    modport master (
        output IN_enqValid, IN_enqUOp, IN_enqReadyA, IN_enqReadyB,
        output IN_wbHasResult, IN_wbUOp, IN_invalidate, IN_invalidateSqN, IN_stall,
        input  OUT_full, OUT_freeCount, OUT_uopValid, OUT_uop
    );

    modport slave (
        input  IN_enqValid, IN_enqUOp, IN_enqReadyA, IN_enqReadyB,
        input  IN_wbHasResult, IN_wbUOp, IN_invalidate, IN_invalidateSqN, IN_stall,
        output OUT_full, OUT_freeCount, OUT_uopValid, OUT_uop
    );

endinterface

// File: rtl/issue_select.sv
// Combinational oldest-ready picker.
//   valid, ready : per-entry occupancy and operand readiness
//   sqn          : per-entry sequence number
//   found        : at least one entry is valid and ready
//   index        : position of the oldest such entry (don't-care when !found)
// Built as a binary tournament: leaves sit at LEAVES+k of a heap-ordered
// array and each inner node keeps the older of its two children.
module issue_select
    import issue_queue_pkg::*;
#(
    parameter int SIZE      = 8,
    parameter int IDX_WIDTH = 3
) (
    input  logic [SIZE-1:0]                valid,
    input  logic [SIZE-1:0]                ready,
    input  logic [SIZE-1:0][SQN_WIDTH-1:0] sqn,
    output logic                           found,
    output logic [IDX_WIDTH-1:0]           index
);

    localparam int LEAVES = 1 << IDX_WIDTH;

    logic                 node_valid [2*LEAVES];
    logic [IDX_WIDTH-1:0] node_idx   [2*LEAVES];
    logic [SQN_WIDTH-1:0] node_sqn   [2*LEAVES];

    // Nodes are evaluated from the leaves upwards so every parent reads
    // children that were already resolved earlier in the same pass.
    always_comb begin
        for (int n = 0; n < 2 * LEAVES; n++) begin
            node_valid[n] = 1'b0;
            node_idx[n]   = '0;
            node_sqn[n]   = '0;
        end
        for (int k = 0; k < LEAVES; k++) begin
            if (k < SIZE) begin
                node_valid[LEAVES+k] = valid[k] && ready[k];
                node_sqn[LEAVES+k]   = sqn[k];
            end
            node_idx[LEAVES+k] = IDX_WIDTH'(k);
        end
        for (int n = LEAVES - 1; n >= 1; n--) begin
            if (node_valid[2*n] &&
                (!node_valid[2*n+1] || !is_younger(node_sqn[2*n], node_sqn[2*n+1]))) begin
                node_idx[n] = node_idx[2*n];
                node_sqn[n] = node_sqn[2*n];
            end else begin
                node_idx[n] = node_idx[2*n+1];
                node_sqn[n] = node_sqn[2*n+1];
            end
            node_valid[n] = node_valid[2*n] || node_valid[2*n+1];
        end
        found = node_valid[1];
        index = node_idx[1];
    end

endmodule

// File: rtl/issue_queue.sv
// Single-issue reservation station in front of operand load.
//   clk, rst : clock and synchronous active-high reset
//   bus      : issue_queue_if slave port (enqueue, writeback snoop,
//              branch invalidation, stall, registered issue output)
// Entries are filled lowest-free-first; issue order is purely by age.
module issue_queue
    import issue_queue_pkg::*;
#(
    parameter int SIZE    = 8,
    parameter int NUM_WBS = 3
) (
    input  logic         clk,
    input  logic         rst,
    issue_queue_if.slave bus
);

    localparam int IDX_WIDTH = (SIZE > 1) ? $clog2(SIZE) : 1;
    localparam int CNT_WIDTH = $clog2(SIZE + 1);

    logic [SIZE-1:0]      valid;
    logic [SIZE-1:0]      rdy_a;
    logic [SIZE-1:0]      rdy_b;
    R_UOp                 entries [SIZE];
    logic [CNT_WIDTH-1:0] free_count;
    logic                 uop_valid;
    R_UOp                 uop;

    logic [SIZE-1:0]                wake_a;
    logic [SIZE-1:0]                wake_b;
    logic [SIZE-1:0]                cleared;
    logic [SIZE-1:0][SQN_WIDTH-1:0] sqns;
    logic                           found;
    logic [IDX_WIDTH-1:0]           sel_idx;
    R_UOp                           sel_uop;
    logic                           issue_do;
    logic                           sel_killed;
    logic                           enq_do;
    logic [IDX_WIDTH-1:0]           enq_idx;
    logic                           enq_rdy_a;
    logic                           enq_rdy_b;
    logic [CNT_WIDTH-1:0]           clear_cnt;
    logic                           unused_wb;

    // A tag of zero never matches because a zero tagDst is not a real result.
    function automatic logic wb_match(input logic [TAG_WIDTH-1:0] tag,
                                      input logic [NUM_WBS-1:0]   has,
                                      input RES_UOp [NUM_WBS-1:0] wbs);
        logic hit;
        hit = 1'b0;
        for (int j = 0; j < NUM_WBS; j++) begin
            if (has[j] && (wbs[j].tagDst != '0) && (wbs[j].tagDst == tag)) begin
                hit = 1'b1;
            end
        end
        return hit;
    endfunction

    issue_select #(
        .SIZE      (SIZE),
        .IDX_WIDTH (IDX_WIDTH)
    ) u_select (
        .valid (valid),
        .ready (rdy_a & rdy_b),
        .sqn   (sqns),
        .found (found),
        .index (sel_idx)
    );

    // Per-entry wakeup plus the set of entries that disappear at this edge
    // (flushed as too young, or handed to the load stage).
    always_comb begin
        clear_cnt = '0;
        for (int i = 0; i < SIZE; i++) begin
            sqns[i]    = entries[i].sqN;
            wake_a[i]  = wb_match(entries[i].tagA, bus.IN_wbHasResult, bus.IN_wbUOp);
            wake_b[i]  = wb_match(entries[i].tagB, bus.IN_wbHasResult, bus.IN_wbUOp);
            cleared[i] = valid[i] &&
                         ((bus.IN_invalidate && is_younger(entries[i].sqN, bus.IN_invalidateSqN)) ||
                          (issue_do && (sel_idx == IDX_WIDTH'(i))));
            if (cleared[i]) begin
                clear_cnt = clear_cnt + CNT_WIDTH'(1);
            end
        end
    end

    // Enqueue goes to the lowest free slot; full comes from the registered
    // count, so a slot freed by this cycle's issue is not reusable yet.
    always_comb begin
        enq_idx = '0;
        for (int i = SIZE - 1; i >= 0; i--) begin
            if (!valid[i]) begin
                enq_idx = IDX_WIDTH'(i);
            end
        end
        enq_do = bus.IN_enqValid && (free_count != '0) &&
                 !(bus.IN_invalidate && is_younger(bus.IN_enqUOp.sqN, bus.IN_invalidateSqN));
        enq_rdy_a = bus.IN_enqReadyA || (bus.IN_enqUOp.tagA == '0) ||
                    wb_match(bus.IN_enqUOp.tagA, bus.IN_wbHasResult, bus.IN_wbUOp);
        enq_rdy_b = bus.IN_enqReadyB || (bus.IN_enqUOp.tagB == '0) || bus.IN_enqUOp.immB ||
                    wb_match(bus.IN_enqUOp.tagB, bus.IN_wbHasResult, bus.IN_wbUOp);
        sel_uop    = entries[sel_idx];
        issue_do   = !bus.IN_stall && found;
        sel_killed = bus.IN_invalidate && is_younger(sel_uop.sqN, bus.IN_invalidateSqN);
    end

    // Only the destination tag of a writeback matters here; the rest of the
    // result record is folded away so it is visibly intentional.
    always_comb begin
        unused_wb = 1'b0;
        for (int j = 0; j < NUM_WBS; j++) begin
            unused_wb = unused_wb ^ (^bus.IN_wbUOp[j].result) ^ (^bus.IN_wbUOp[j].sqN);
        end
    end

    // Entry array, free counter and the issue register all advance together;
    // a selected-but-flushed uop is still freed, just never marked valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid      <= '0;
            rdy_a      <= '0;
            rdy_b      <= '0;
            free_count <= CNT_WIDTH'(SIZE);
            uop_valid  <= 1'b0;
            uop        <= '0;
        end else begin
            for (int i = 0; i < SIZE; i++) begin
                if (cleared[i]) begin
                    valid[i] <= 1'b0;
                end else if (valid[i]) begin
                    rdy_a[i] <= rdy_a[i] | wake_a[i];
                    rdy_b[i] <= rdy_b[i] | wake_b[i];
                end else if (enq_do && (enq_idx == IDX_WIDTH'(i))) begin
                    valid[i]   <= 1'b1;
                    entries[i] <= bus.IN_enqUOp;
                    rdy_a[i]   <= enq_rdy_a;
                    rdy_b[i]   <= enq_rdy_b;
                end
            end
            free_count <= free_count + clear_cnt - CNT_WIDTH'(enq_do);
            if (!bus.IN_stall) begin
                uop_valid <= found && !sel_killed;
                if (found) begin
                    uop <= sel_uop;
                end
            end else if (bus.IN_invalidate && is_younger(uop.sqN, bus.IN_invalidateSqN)) begin
                uop_valid <= 1'b0;
            end
        end
    end

    assign bus.OUT_uopValid  = uop_valid;
    assign bus.OUT_uop       = uop;
    assign bus.OUT_freeCount = free_count;
    assign bus.OUT_full      = (free_count == '0);

endmodule

// File: tb/tb_issue_queue.sv
// Self-checking bench for issue_queue: a per-cycle vector table for the
// basic issue/wakeup/age-wrap behaviour, then hand-written sequences for
// stall, full, invalidation and mid-run reset.
module tb_issue_queue;
    import issue_queue_pkg::*;

    localparam int SIZE    = 8;
    localparam int NUM_WBS = 3;

    typedef struct {
        logic             enq;
        logic [5:0]       sqn;
        logic [6:0]       tag_a;
        logic             rdy_a;
        logic             wb;
        logic [6:0]       wb_tag;
        logic             stall;
        logic             inv;
        logic [5:0]       inv_sqn;
    } stim_t;

    typedef struct {
        stim_t s;
        logic  exp_valid;
        int    exp_sqn;
        int    exp_free;
    } vec_t;

    logic clk;
    logic rst;
    int   tests;
    int   fails;
    vec_t vecs [18];

    issue_queue_if #(.SIZE(SIZE), .NUM_WBS(NUM_WBS)) bus ();

    issue_queue #(.SIZE(SIZE), .NUM_WBS(NUM_WBS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic stim_t st(input int enq, input int sqn, input int tag_a, input int rdy_a,
                                 input int wb, input int wb_tag, input int stall,
                                 input int inv, input int inv_sqn);
        stim_t s;
        s.enq     = (enq != 0);
        s.sqn     = 6'(sqn);
        s.tag_a   = 7'(tag_a);
        s.rdy_a   = (rdy_a != 0);
        s.wb      = (wb != 0);
        s.wb_tag  = 7'(wb_tag);
        s.stall   = (stall != 0);
        s.inv     = (inv != 0);
        s.inv_sqn = 6'(inv_sqn);
        return s;
    endfunction

    function automatic vec_t row(input stim_t s, input int ev, input int esq, input int ef);
        vec_t v;
        v.s         = s;
        v.exp_valid = (ev != 0);
        v.exp_sqn   = esq;
        v.exp_free  = ef;
        return v;
    endfunction

    function automatic stim_t idle(input int stall);
        return st(0, 0, 0, 0, 0, 0, stall, 0, 0);
    endfunction

    task automatic apply_stimulus(input stim_t s, input int wb_port);
        R_UOp u;
        u        = '0;
        u.imm    = {26'd0, s.sqn};
        u.tagA   = s.tag_a;
        u.tagB   = 7'd0;
        u.immB   = 1'b0;
        u.tagDst = {1'b1, s.sqn};
        u.sqN    = s.sqn;
        u.fu     = FU_INT;
        bus.IN_enqValid      = s.enq;
        bus.IN_enqUOp        = u;
        bus.IN_enqReadyA     = s.rdy_a;
        bus.IN_enqReadyB     = 1'b0;
        bus.IN_wbHasResult   = '0;
        bus.IN_wbUOp         = '0;
        if (s.wb) begin
            bus.IN_wbHasResult[wb_port]   = 1'b1;
            bus.IN_wbUOp[wb_port].tagDst  = s.wb_tag;
            bus.IN_wbUOp[wb_port].result  = 32'hdead_beef;
        end
        bus.IN_invalidate    = s.inv;
        bus.IN_invalidateSqN = s.inv_sqn;
        bus.IN_stall         = s.stall;
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string name, input logic exp_valid,
                                input int exp_sqn, input int exp_free);
        tests++;
        if (bus.OUT_uopValid !== exp_valid) begin
            fails++;
            $display("[TB] FAIL %s valid: got %0b expected %0b", name, bus.OUT_uopValid, exp_valid);
        end
        if (exp_valid) begin
            tests++;
            if (bus.OUT_uop.sqN !== 6'(exp_sqn)) begin
                fails++;
                $display("[TB] FAIL %s sqN: got %0d expected %0d", name, bus.OUT_uop.sqN, exp_sqn);
            end
        end
        tests++;
        if (bus.OUT_freeCount !== 4'(exp_free)) begin
            fails++;
            $display("[TB] FAIL %s freeCount: got %0d expected %0d", name, bus.OUT_freeCount, exp_free);
        end
        tests++;
        if (bus.OUT_full !== (exp_free == 0)) begin
            fails++;
            $display("[TB] FAIL %s full: got %0b expected %0b", name, bus.OUT_full, (exp_free == 0));
        end
    endtask

    task automatic check_uop_zero(input string name);
        tests++;
        if (bus.OUT_uop !== '0) begin
            fails++;
            $display("[TB] FAIL %s uop: got %h expected 0", name, bus.OUT_uop);
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst   = 1'b1;

        // enq, sqn, tagA, rdyA, wb, wbTag, stall, inv, invSqN -> valid, sqN, free
        vecs[0]  = row(st(1, 3, 0, 0, 0, 0, 0, 0, 0), 0, 0, 7);
        vecs[1]  = row(idle(0), 1, 3, 8);
        vecs[2]  = row(idle(0), 0, 0, 8);
        vecs[3]  = row(st(1, 5, 12, 0, 0, 0, 0, 0, 0), 0, 0, 7);
        vecs[4]  = row(st(1, 6, 9, 1, 0, 0, 0, 0, 0), 0, 0, 6);
        vecs[5]  = row(idle(0), 1, 6, 7);
        vecs[6]  = row(st(0, 0, 0, 0, 1, 12, 0, 0, 0), 0, 0, 7);
        vecs[7]  = row(idle(0), 1, 5, 8);
        vecs[8]  = row(st(1, 7, 20, 0, 1, 20, 0, 0, 0), 0, 0, 7);
        vecs[9]  = row(idle(0), 1, 7, 8);
        vecs[10] = row(idle(0), 0, 0, 8);
        vecs[11] = row(st(1, 1, 0, 0, 0, 0, 1, 0, 0), 0, 0, 7);
        vecs[12] = row(st(1, 63, 0, 0, 0, 0, 1, 0, 0), 0, 0, 6);
        vecs[13] = row(st(1, 62, 0, 0, 0, 0, 1, 0, 0), 0, 0, 5);
        vecs[14] = row(idle(0), 1, 62, 6);
        vecs[15] = row(idle(0), 1, 63, 7);
        vecs[16] = row(idle(0), 1, 1, 8);
        vecs[17] = row(idle(0), 0, 0, 8);

        apply_stimulus(idle(0), 0);
        apply_stimulus(idle(0), 0);
        check_output("reset", 1'b0, 0, 8);
        check_uop_zero("reset");
        rst = 1'b0;

        for (int i = 0; i < 18; i++) begin
            apply_stimulus(vecs[i].s, i % NUM_WBS);
            check_output($sformatf("vec%0d", i), vecs[i].exp_valid, vecs[i].exp_sqn, vecs[i].exp_free);
        end

        // Stall holds the output register and the entry array.
        apply_stimulus(st(1, 20, 0, 0, 0, 0, 0, 0, 0), 0);
        check_output("stall_a", 1'b0, 0, 7);
        apply_stimulus(st(1, 21, 0, 0, 0, 0, 0, 0, 0), 0);
        check_output("stall_b", 1'b1, 20, 7);
        apply_stimulus(st(1, 22, 0, 0, 0, 0, 1, 0, 0), 0);
        check_output("stall_c", 1'b1, 20, 6);
        for (int k = 0; k < 3; k++) begin
            apply_stimulus(idle(1), 0);
            check_output($sformatf("stall_hold%0d", k), 1'b1, 20, 6);
        end
        apply_stimulus(idle(0), 0);
        check_output("stall_rel0", 1'b1, 21, 7);
        apply_stimulus(idle(0), 0);
        check_output("stall_rel1", 1'b1, 22, 8);
        apply_stimulus(idle(0), 0);
        check_output("stall_rel2", 1'b0, 0, 8);

        // Fill to full, drop extra enqueues, then drain in age order.
        for (int k = 0; k < 8; k++) begin
            apply_stimulus(st(1, 30 + k, 0, 0, 0, 0, 1, 0, 0), 0);
            check_output($sformatf("fill%0d", k), 1'b0, 0, 7 - k);
        end
        apply_stimulus(st(1, 38, 0, 0, 0, 0, 1, 0, 0), 0);
        check_output("full_drop", 1'b0, 0, 0);
        apply_stimulus(st(1, 39, 0, 0, 0, 0, 0, 0, 0), 0);
        check_output("full_issue_enq", 1'b1, 30, 1);
        for (int k = 1; k < 8; k++) begin
            apply_stimulus(idle(0), 0);
            check_output($sformatf("drain%0d", k), 1'b1, 30 + k, 1 + k);
        end
        apply_stimulus(idle(0), 0);
        check_output("drain_end", 1'b0, 0, 8);

        // Invalidate while the output register holds a younger uop under stall.
        apply_stimulus(st(1, 13, 0, 0, 0, 0, 0, 0, 0), 0);
        check_output("inv_a", 1'b0, 0, 7);
        apply_stimulus(st(1, 10, 0, 0, 0, 0, 0, 0, 0), 0);
        check_output("inv_b", 1'b1, 13, 7);
        apply_stimulus(st(1, 11, 0, 0, 0, 0, 1, 0, 0), 0);
        check_output("inv_c", 1'b1, 13, 6);
        apply_stimulus(st(1, 12, 0, 0, 0, 0, 1, 0, 0), 0);
        check_output("inv_d", 1'b1, 13, 5);
        apply_stimulus(st(0, 0, 0, 0, 0, 0, 1, 1, 11), 0);
        check_output("inv_flush", 1'b0, 0, 6);
        apply_stimulus(idle(0), 0);
        check_output("inv_f", 1'b1, 10, 7);
        apply_stimulus(idle(0), 0);
        check_output("inv_g", 1'b1, 11, 8);
        apply_stimulus(idle(0), 0);
        check_output("inv_h", 1'b0, 0, 8);

        // Selected uop flushed in the same cycle, younger enqueue dropped,
        // equal sqN survives.
        apply_stimulus(st(1, 45, 0, 0, 0, 0, 1, 0, 0), 0);
        check_output("kill_a", 1'b0, 0, 7);
        apply_stimulus(st(1, 46, 0, 0, 0, 0, 0, 1, 44), 0);
        check_output("kill_sel", 1'b0, 0, 8);
        apply_stimulus(idle(0), 0);
        check_output("kill_after", 1'b0, 0, 8);
        apply_stimulus(st(1, 50, 0, 0, 0, 0, 1, 0, 0), 0);
        check_output("equal_a", 1'b0, 0, 7);
        apply_stimulus(st(0, 0, 0, 0, 0, 0, 0, 1, 50), 0);
        check_output("equal_issue", 1'b1, 50, 8);
        apply_stimulus(idle(0), 0);
        check_output("equal_after", 1'b0, 0, 8);

        // Reset in the middle of activity clears queue and output register.
        apply_stimulus(st(1, 60, 0, 0, 0, 0, 0, 0, 0), 0);
        check_output("mrst_a", 1'b0, 0, 7);
        apply_stimulus(st(1, 61, 0, 0, 0, 0, 0, 0, 0), 0);
        check_output("mrst_b", 1'b1, 60, 7);
        rst = 1'b1;
        apply_stimulus(st(1, 62, 0, 0, 0, 0, 0, 0, 0), 0);
        check_output("mrst_rst", 1'b0, 0, 8);
        check_uop_zero("mrst_rst");
        rst = 1'b0;
        apply_stimulus(idle(0), 0);
        check_output("mrst_after", 1'b0, 0, 8);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/issue_queue.md
Name: issue_queue

Overview:
- Single-issue scheduler (reservation station) in front of the operand-load stage.
- Buffers renamed uops and tracks source-tag readiness by snooping writeback ports.
- Each cycle it selects the oldest ready uop and presents it registered to the operand-load stage.
- Honours the load stage's stall and the global sqN-based branch invalidation.

Parameters:
- SIZE, 8, number of queue entries.
- NUM_WBS, 3, number of writeback snoop ports.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- IN_enqValid  in  1  enqueue request this cycle.
- IN_enqUOp  in  R_UOp  uop to enqueue.
- IN_enqReadyA  in  1  srcA is already available in the register file (from the scoreboard).
- IN_enqReadyB  in  1  srcB is already available in the register file.
- OUT_full  out  1  no free entry; an enqueue this cycle is ignored.
- OUT_freeCount  out  $clog2(SIZE+1)  number of free entries.
- IN_wbHasResult  in  NUM_WBS x 1  writeback valid per port.
- IN_wbUOp  in  NUM_WBS x RES_UOp  writeback uop; only tagDst is used.
- IN_invalidate  in  1  flush every uop younger than IN_invalidateSqN.
- IN_invalidateSqN  in  6  sqN of the youngest surviving uop.
- IN_stall  in  1  load stage cannot accept a new uop.
- OUT_uopValid  out  1  issued uop valid.
- OUT_uop  out  R_UOp  issued uop (registered).

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous and active-high.
- Reset values: all entries invalid; OUT_uopValid=0; OUT_uop=0; OUT_freeCount=SIZE; OUT_full=0. Reset asserted mid-operation discards all contents on the next edge, including the output register.
- Entry state: valid, uop, rdyA, rdyB.
- Readiness rules:
  - tagA==0 means ready.
  - tagB==0 or immB means srcB ready.
- Age: "younger" means $signed(a.sqN - b.sqN) > 0, using 6-bit wrap-around arithmetic.
- Enqueue:
  - When IN_enqValid && !OUT_full, write the uop into the lowest-index free entry.
  - rdyX is set from IN_enqReadyX, OR'd with tag-zero/immB, OR'd with a same-cycle writeback tag match.
  - Enqueue while full is dropped silently.
- Wakeup:
  - For each valid entry and each port j, IN_wbHasResult[j] && IN_wbUOp[j].tagDst != 0 && tag match sets rdyA/rdyB.
  - Multiple matches are harmless.
- Select and issue:
  - Combinational select of the oldest valid entry with rdyA && rdyB, using pre-edge state.
  - A wakeup in cycle N makes the entry eligible for issue in cycle N+1. The load stage forwards that WB value in the same cycle.
  - If !IN_stall: OUT_uop <= selected uop, OUT_uopValid <= found, and the selected entry is freed.
  - If no entry is ready: OUT_uopValid <= 0.
  - If IN_stall: the output register is held and no entry is removed.
  - Latency: enqueue with both sources ready in cycle N leads to OUT_uopValid in cycle N+2 at the earliest (entry written at edge N, selected in N+1, registered at edge N+1).
- Invalidate:
  - Every valid entry younger than IN_invalidateSqN is cleared at the edge.
  - A same-cycle enqueue of a younger uop is dropped.
  - A same-cycle selection of a younger uop is not issued: OUT_uopValid <= 0 and the entry is freed anyway.
  - If the held output register (IN_stall=1) contains a younger uop, OUT_uopValid <= 0 even while stalled.
  - Older or equal sqN survives.
- Free count:
  - OUT_freeCount is the registered count of invalid entries. OUT_full = (OUT_freeCount==0).
  - Same-cycle issue and enqueue when full: the enqueue is still refused, because full is based on the registered count.
- Simultaneous enqueue, issue, wakeup and invalidate in one cycle are all resolved in a single edge following the rules above. The count updates as old − enq + issued + invalidated, and never leaves the range 0..SIZE.

Decomposition:
- Shared package: R_UOp, RES_UOp, FuncUnit, SQN_WIDTH=6, and an is_younger(a,b) function.
- Sub-module issue_select (combinational):
  - Inputs: valid/ready vectors and sqN array.
  - Outputs: found and index.
  - Implemented as a pairwise-oldest reduction tree.

Test Plan:
1. Reset, then enqueue sqN=3 with tagA=0, tagB=0 -> OUT_uopValid=1 with sqN=3 exactly two cycles later; OUT_freeCount back to 8.
2. Enqueue sqN=5 (tagA=12, not ready) and then sqN=6 (ready) -> sqN=6 issues first. Then WB tagDst=12 in cycle N -> sqN=5 issues at edge N+1.
3. Ready entries with sqN=62, 63, 1 (wrap) enqueued in order 1, 63, 62 -> issue order 62, 63, 1.
4. Hold IN_stall=1 for 3 cycles with 2 ready entries -> OUT_uop unchanged and OUT_freeCount constant. Release stall -> the next oldest issues.
5. Fill 8 entries -> OUT_full=1. A 9th enqueue is dropped; the count stays 0 until an issue.
6. Entries sqN=10, 11, 12, output register holding sqN=13 under stall, invalidate with sqN=11 -> entry 12 cleared, OUT_uopValid=0, entries 10 and 11 remain; OUT_freeCount increments by 1, plus 1 if issued.
